// File: rtl/interrupt_controller_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared definitions for the ForthCPU interrupt controller.
//   - intc_state_t : sequencing states (INTC_IDLE, INTC_REQ, INTC_SVC)
//   - IDX_W        : width of an IRQ line index (up to 8 lines)
//   - intc_vector  : vector address for a given line index
// -----------------------------------------------------------------------------
package interrupt_controller_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    INTC_IDLE = 2'd0,
    INTC_REQ  = 2'd1,
    INTC_SVC  = 2'd2
  } intc_state_t;

  // Vector address = base + (idx << shift); 16-bit arithmetic, wraps silently.
  function automatic logic [15:0] intc_vector(input logic [15:0]      base,
                                              input logic [IDX_W-1:0] idx,
                                              input int unsigned      shift);
    logic [15:0] offset;
    offset = {13'd0, idx} << shift;
    return base + offset;
  endfunction

endpackage

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
// Combinational fixed-priority encoder; the lowest set index wins.
// Ports:
//   PEND  in  NUM_IRQ  pending (requested and enabled) lines
//   VALID out 1        at least one line pending
//   IDX   out 3        index of the winning line (0 when none pending)
// -----------------------------------------------------------------------------
module irq_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] PEND,
  output logic               VALID,
  output logic [IDX_W-1:0]   IDX
);

  // Scan from the top down so the lowest pending index is the last one written.
  always_comb begin
    VALID = |PEND;
    IDX   = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      IDX = PEND[i] ? i[IDX_W-1:0] : IDX;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Sequences interrupt entry/exit for the ForthCPU core: fixed-priority
// arbitration of level IRQ lines, global interrupt enable (EI/DI/RETI),
// request to the fetch sequencer at instruction boundaries, vector supply and
// wake-up of a halted core.
// Ports:
//   CLK, RESET                   clock, asynchronous active-high reset
//   FETCH/DECODE/EXECUTE/COMMIT  phase strobes (only COMMIT is used)
//   IRQ[NUM_IRQ]                 level requests, held until acked
//   MASK_WE, MASK_DATA           load per-line enable register
//   EIX, DIX, RETIX              decoder strobes, sampled at COMMIT
//   HALTED                       core is halted
//   INT_TAKEN                    sequencer has entered the vector
//   INT_REQ, INT_VECTOR          request and target address
//   INT_ACK[NUM_IRQ]             one-hot acknowledge pulse
//   IE, IN_SERVICE               global enable, handler active
//   WAKE                         one-cycle restart pulse for a halted core
// -----------------------------------------------------------------------------
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter logic [15:0] VECTOR_BASE  = 16'h0010,
  parameter int          VECTOR_SHIFT = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FETCH,
  input  logic               DECODE,
  input  logic               EXECUTE,
  input  logic               COMMIT,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               MASK_WE,
  input  logic [NUM_IRQ-1:0] MASK_DATA,
  input  logic               EIX,
  input  logic               DIX,
  input  logic               RETIX,
  input  logic               HALTED,
  input  logic               INT_TAKEN,
  output logic               INT_REQ,
  output logic [15:0]        INT_VECTOR,
  output logic [NUM_IRQ-1:0] INT_ACK,
  output logic               IE,
  output logic               IN_SERVICE,
  output logic               WAKE
);

  intc_state_t        state;
  intc_state_t        state_nx;
  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] pend;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_idx;
  logic [IDX_W-1:0]   idx_lat;
  logic [IDX_W-1:0]   idx_nx;
  logic               int_req_nx;
  logic [15:0]        vector_nx;
  logic [NUM_IRQ-1:0] ack_nx;
  logic               ie_nx;
  logic               in_service_nx;
  logic               wake_cond;
  logic               wake_prev;
  logic               unused_phases;

  // Only COMMIT matters here; the other phase strobes are deliberately ignored.
  assign unused_phases = ^{FETCH, DECODE, EXECUTE};

  assign pend      = IRQ & irq_en;
  assign wake_cond = HALTED & (|pend);

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ)
  ) u_enc (
    .PEND  (pend),
    .VALID (enc_valid),
    .IDX   (enc_idx)
  );

  // Per-line enable register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_en <= '0;
    end else if (MASK_WE) begin
      irq_en <= MASK_DATA;
    end else begin
      irq_en <= irq_en;
    end
  end

  // Next-state and next-output logic for the entry/exit sequencer.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx_lat;
    int_req_nx    = INT_REQ;
    vector_nx     = INT_VECTOR;
    ack_nx        = '0;
    ie_nx         = IE;
    in_service_nx = IN_SERVICE;
    case (state)
      INTC_IDLE: begin
        if (COMMIT) begin
          // DI wins over EI in the same commit.
          if (DIX) begin
            ie_nx = 1'b0;
          end else if (EIX) begin
            ie_nx = 1'b1;
          end else begin
            ie_nx = IE;
          end
          // Uses the registered IE, so the commit that executes EI never takes.
          if (IE && enc_valid && !DIX) begin
            state_nx   = INTC_REQ;
            idx_nx     = enc_idx;
            int_req_nx = 1'b1;
            vector_nx  = intc_vector(VECTOR_BASE, enc_idx, VECTOR_SHIFT);
          end else begin
            state_nx = INTC_IDLE;
          end
        end else begin
          state_nx = INTC_IDLE;
        end
      end
      INTC_REQ: begin
        // Vector and latched index stay frozen; the latched line is acked
        // even if its request has dropped meanwhile.
        if (INT_TAKEN) begin
          state_nx      = INTC_SVC;
          int_req_nx    = 1'b0;
          ie_nx         = 1'b0;
          in_service_nx = 1'b1;
          for (int i = 0; i < NUM_IRQ; i++) begin
            ack_nx[i] = (idx_lat == i[IDX_W-1:0]);
          end
        end else if (COMMIT) begin
          if (DIX) begin
            ie_nx = 1'b0;
          end else if (EIX) begin
            ie_nx = 1'b1;
          end else begin
            ie_nx = IE;
          end
        end else begin
          state_nx = INTC_REQ;
        end
      end
      INTC_SVC: begin
        // Handlers do not nest: EI/DI are ignored until RETI.
        if (COMMIT && RETIX) begin
          state_nx      = INTC_IDLE;
          ie_nx         = 1'b1;
          in_service_nx = 1'b0;
        end else begin
          state_nx = INTC_SVC;
        end
      end
      default: begin
        state_nx      = INTC_IDLE;
        int_req_nx    = 1'b0;
        ie_nx         = 1'b0;
        in_service_nx = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= INTC_IDLE;
      idx_lat    <= 3'd0;
      INT_REQ    <= 1'b0;
      INT_VECTOR <= 16'h0000;
      INT_ACK    <= '0;
      IE         <= 1'b0;
      IN_SERVICE <= 1'b0;
    end else begin
      state      <= state_nx;
      idx_lat    <= idx_nx;
      INT_REQ    <= int_req_nx;
      INT_VECTOR <= vector_nx;
      INT_ACK    <= ack_nx;
      IE         <= ie_nx;
      IN_SERVICE <= in_service_nx;
    end
  end

  // Wake pulse on the rising edge of (HALTED & pending), independent of IE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wake_prev <= 1'b0;
      WAKE      <= 1'b0;
    end else begin
      wake_prev <= wake_cond;
      WAKE      <= wake_cond & ~wake_prev;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed self-checking bench for interrupt_controller. Inputs are driven and
// outputs sampled on the falling clock edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FETCH, DECODE, EXECUTE, COMMIT;
  logic [3:0]  IRQ;
  logic        MASK_WE;
  logic [3:0]  MASK_DATA;
  logic        EIX, DIX, RETIX;
  logic        HALTED;
  logic        INT_TAKEN;
  logic        INT_REQ;
  logic [15:0] INT_VECTOR;
  logic [3:0]  INT_ACK;
  logic        IE;
  logic        IN_SERVICE;
  logic        WAKE;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller #(
    .NUM_IRQ      (4),
    .VECTOR_BASE  (16'h0010),
    .VECTOR_SHIFT (2)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FETCH      (FETCH),
    .DECODE     (DECODE),
    .EXECUTE    (EXECUTE),
    .COMMIT     (COMMIT),
    .IRQ        (IRQ),
    .MASK_WE    (MASK_WE),
    .MASK_DATA  (MASK_DATA),
    .EIX        (EIX),
    .DIX        (DIX),
    .RETIX      (RETIX),
    .HALTED     (HALTED),
    .INT_TAKEN  (INT_TAKEN),
    .INT_REQ    (INT_REQ),
    .INT_VECTOR (INT_VECTOR),
    .INT_ACK    (INT_ACK),
    .IE         (IE),
    .IN_SERVICE (IN_SERVICE),
    .WAKE       (WAKE)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic do_commit(input logic ei, input logic di, input logic reti);
    COMMIT = 1'b1; EIX = ei; DIX = di; RETIX = reti;
    cyc();
    COMMIT = 1'b0; EIX = 1'b0; DIX = 1'b0; RETIX = 1'b0;
  endtask

  task automatic load_mask(input logic [3:0] m);
    MASK_WE = 1'b1; MASK_DATA = m;
    cyc();
    MASK_WE = 1'b0;
  endtask

  task automatic take();
    INT_TAKEN = 1'b1;
    cyc();
    INT_TAKEN = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; FETCH = 1'b0; DECODE = 1'b0; EXECUTE = 1'b0; COMMIT = 1'b0;
    IRQ = 4'b0000; MASK_WE = 1'b0; MASK_DATA = 4'b0000;
    EIX = 1'b0; DIX = 1'b0; RETIX = 1'b0; HALTED = 1'b0; INT_TAKEN = 1'b0;
    repeat (2) cyc();
    check_val("rst_int_req", 32'(INT_REQ), 32'd0);
    check_val("rst_vector", 32'(INT_VECTOR), 32'h0);
    check_val("rst_ack", 32'(INT_ACK), 32'h0);
    check_val("rst_ie", 32'(IE), 32'd0);
    check_val("rst_in_service", 32'(IN_SERVICE), 32'd0);
    check_val("rst_wake", 32'(WAKE), 32'd0);
    RESET = 1'b0;

    // Single IRQ on line 2
    load_mask(4'b0100);
    do_commit(1'b1, 1'b0, 1'b0);
    check_val("ei_sets_ie", 32'(IE), 32'd1);
    check_val("ei_no_req", 32'(INT_REQ), 32'd0);
    IRQ = 4'b0100;
    cyc();
    check_val("no_req_without_commit", 32'(INT_REQ), 32'd0);
    do_commit(1'b0, 1'b0, 1'b0);
    check_val("single_req", 32'(INT_REQ), 32'd1);
    check_val("single_vector", 32'(INT_VECTOR), 32'h0018);
    cyc();
    check_val("req_holds", 32'(INT_REQ), 32'd1);
    take();
    IRQ = 4'b0000;
    check_val("single_ack", 32'(INT_ACK), 32'h4);
    check_val("taken_ie_clr", 32'(IE), 32'd0);
    check_val("taken_in_service", 32'(IN_SERVICE), 32'd1);
    check_val("taken_req_drop", 32'(INT_REQ), 32'd0);
    cyc();
    check_val("ack_one_cycle", 32'(INT_ACK), 32'h0);
    do_commit(1'b0, 1'b0, 1'b1);
    check_val("reti_ie", 32'(IE), 32'd1);
    check_val("reti_in_service", 32'(IN_SERVICE), 32'd0);

    // Priority: lines 1 and 3, then line 0 rises during REQ
    load_mask(4'b1111);
    IRQ = 4'b1010;
    do_commit(1'b0, 1'b0, 1'b0);
    check_val("prio_req", 32'(INT_REQ), 32'd1);
    check_val("prio_vector", 32'(INT_VECTOR), 32'h0014);
    IRQ = 4'b1011;
    cyc();
    check_val("prio_vector_frozen", 32'(INT_VECTOR), 32'h0014);
    take();
    check_val("prio_ack", 32'(INT_ACK), 32'h2);
    IRQ = 4'b1001;
    // RETI with pending IRQ returns to IDLE without requesting
    do_commit(1'b0, 1'b0, 1'b1);
    check_val("reti_pend_no_req", 32'(INT_REQ), 32'd0);
    check_val("reti_pend_ie", 32'(IE), 32'd1);
    do_commit(1'b0, 1'b0, 1'b0);
    check_val("after_reti_req", 32'(INT_REQ), 32'd1);
    check_val("after_reti_vector", 32'(INT_VECTOR), 32'h0010);
    take();
    check_val("line0_ack", 32'(INT_ACK), 32'h1);
    IRQ = 4'b1000;
    do_commit(1'b0, 1'b0, 1'b1);

    // DI vs pending IRQ, then EI shadow
    do_commit(1'b0, 1'b1, 1'b0);
    check_val("di_no_req", 32'(INT_REQ), 32'd0);
    check_val("di_ie", 32'(IE), 32'd0);
    do_commit(1'b1, 1'b0, 1'b0);
    check_val("ei_shadow_no_req", 32'(INT_REQ), 32'd0);
    check_val("ei_shadow_ie", 32'(IE), 32'd1);
    do_commit(1'b0, 1'b0, 1'b0);
    check_val("after_shadow_req", 32'(INT_REQ), 32'd1);
    check_val("after_shadow_vector", 32'(INT_VECTOR), 32'h001C);
    take();
    check_val("line3_ack", 32'(INT_ACK), 32'h8);
    IRQ = 4'b0000;
    do_commit(1'b0, 1'b0, 1'b1);
    do_commit(1'b1, 1'b1, 1'b0);
    check_val("ei_di_both_di_wins", 32'(IE), 32'd0);

    // Halt / wake with IE=0
    HALTED = 1'b1;
    IRQ = 4'b0001;
    cyc();
    check_val("wake_pulse", 32'(WAKE), 32'd1);
    do_commit(1'b0, 1'b0, 1'b0);
    check_val("wake_once", 32'(WAKE), 32'd0);
    check_val("wake_no_req", 32'(INT_REQ), 32'd0);
    IRQ = 4'b0000;
    cyc();
    load_mask(4'b1110);
    IRQ = 4'b0001;
    cyc();
    check_val("masked_no_wake", 32'(WAKE), 32'd0);
    cyc();
    check_val("masked_no_wake2", 32'(WAKE), 32'd0);
    IRQ = 4'b0000;
    HALTED = 1'b0;

    // Asynchronous reset while in REQ
    load_mask(4'b1111);
    do_commit(1'b1, 1'b0, 1'b0);
    IRQ = 4'b0100;
    do_commit(1'b0, 1'b0, 1'b0);
    check_val("pre_reset_req", 32'(INT_REQ), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check_val("async_rst_req", 32'(INT_REQ), 32'd0);
    check_val("async_rst_ie", 32'(IE), 32'd0);
    check_val("async_rst_vector", 32'(INT_VECTOR), 32'h0);
    cyc();
    RESET = 1'b0;
    HALTED = 1'b1;
    cyc();
    check_val("rst_irq_en_clear_no_wake", 32'(WAKE), 32'd0);
    HALTED = 1'b0;
    do_commit(1'b1, 1'b0, 1'b0);
    do_commit(1'b0, 1'b0, 1'b0);
    check_val("rst_idle_no_req", 32'(INT_REQ), 32'd0);
    IRQ = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
